gray_sweep_ctrl: RTL

Sequencer for the team's binary-to-Gray conversion path. On a start command it walks a binary code from `first` to `last` (modulo 2^WIDTH), converts each value to Gray and streams each (binary, Gray) pair over a valid/ready handshake. A programmable gap is inserted between beats. Sits between a test/stimulus controller and any consumer of Gray-coded counts, such as a display, a CDC pointer check or a logger.

---
 rtl/gray_sweep_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/gray_sweep_ctrl.sv
// Binary sweep sequencer: walks first..last (mod 2^WIDTH), streams (binary, Gray) pairs over valid/ready.
// Optional GRAY_SWEEP_CHECK_EN adds the adj_err output, flagging transfers whose Gray step is not exactly one bit.
module gray_sweep_ctrl #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] first,
  input  logic [WIDTH-1:0] last,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_bin,
  output logic [WIDTH-1:0] out_gray,
  output logic             busy,
  output logic             done
`ifdef GRAY_SWEEP_CHECK_EN
  ,
  output logic             adj_err
`endif
);

  // Counter is loaded with GAP_CYCLES-1 and counts down to zero.
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, GAP, VALID, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] last_q;
  logic [GW-1:0]    gap_cnt;
  logic             xfer;
  logic [WIDTH-1:0] next_bin;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign xfer     = out_valid & out_ready;
  assign next_bin = out_bin + WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_q    <= '0;
      gap_cnt   <= '0;
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_gray  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              last_q    <= last;
              out_bin   <= first;
              out_gray  <= to_gray(first);
              out_valid <= 1'b1;
              busy      <= 1'b1;
              state     <= VALID;
            end
          end
          VALID: begin
            if (xfer) begin
              if (out_bin == last_q) begin
                out_valid <= 1'b0;
                done      <= 1'b1;
                state     <= DONE;
              end else begin
                out_bin  <= next_bin;
                out_gray <= to_gray(next_bin);
                if (GAP_CYCLES > 0) begin
                  out_valid <= 1'b0;
                  gap_cnt   <= GAP_LOAD;
                  state     <= GAP;
                end
              end
            end
          end
          GAP: begin
            if (gap_cnt == '0) begin
              out_valid <= 1'b1;
              state     <= VALID;
            end else begin
              gap_cnt <= gap_cnt - GW'(1);
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef GRAY_SWEEP_CHECK_EN
  logic [WIDTH-1:0] prev_gray;
  logic             have_prev;
  logic [WIDTH-1:0] diff;

  assign diff = out_gray ^ prev_gray;

  // An aborted beat is not a transfer, so it neither updates nor checks the history.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_gray <= '0;
      have_prev <= 1'b0;
      adj_err   <= 1'b0;
    end else if (state == IDLE && start) begin
      have_prev <= 1'b0;
      adj_err   <= 1'b0;
    end else if (state == VALID && xfer && !abort) begin
      prev_gray <= out_gray;
      have_prev <= 1'b1;
      if (have_prev && !((diff != '0) && ((diff & (diff - WIDTH'(1))) == '0)))
        adj_err <= 1'b1;
    end
  end
`endif

endmodule
